// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader: FSM encoding and timer sizing.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // A disabled timeout (0) still needs a 1-bit counter to keep widths legal.
  function automatic int timer_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_burst_reader_stream_out_reg.sv
// Single-entry valid/ready output register carrying data plus the last flag.
module fifo_burst_reader_stream_out_reg #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  output logic          m_last
);

  logic [DW:0] word_p0;
  logic        vld_p0;

  // Output stage: a load always wins; otherwise an accepted beat empties the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_p0 <= '0;
      vld_p0  <= 1'b0;
    end else if (load) begin
      word_p0 <= {load_last, load_data};
      vld_p0  <= 1'b1;
    end else if (vld_p0 && m_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign m_data  = word_p0[DW-1:0];
  assign m_last  = word_p0[DW];
  assign m_valid = vld_p0;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side FIFO controller: drains first-word-fall-through data in bursts onto a registered stream.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int AW        = 5,
  parameter int DW        = 64,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] fifo_dout,
  input  logic [AW:0]   fifo_cntr,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  input  logic          flush,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic [AW:0]   burst_len,
  output logic          busy
);

  localparam int              TW    = timer_w(TIMEOUT);
  localparam bit              TO_EN = (TIMEOUT != 0);
  localparam logic [TW-1:0]   TO    = TW'(TIMEOUT);
  localparam logic [TW-1:0]   T_ONE = TW'(1);
  localparam logic [AW:0]     BL    = (AW+1)'(BURST_LEN);
  localparam logic [AW:0]     ONE   = (AW+1)'(1);

  state_t        state, state_nx;
  logic [AW:0]   issued;
  logic [AW:0]   issued_inc;
  logic [AW:0]   len_nx;
  logic [TW-1:0] idle_timer;
  logic          start_full, start_part, start;
  logic          load_last;

  assign issued_inc = issued + ONE;
  assign start_full = (fifo_cntr >= BL);
  assign start_part = (fifo_cntr != '0) && (flush || (TO_EN && (idle_timer == TO)));
  assign len_nx     = start_full ? BL : fifo_cntr;
  assign load_last  = (issued_inc == burst_len);
  assign busy       = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    fifo_rd  = 1'b0;
    start    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_full || start_part) begin
          state_nx = ST_BURST;
          start    = 1'b1;
        end
      end
      ST_BURST: begin
        fifo_rd = !fifo_empty && (!m_valid || m_ready) && (issued < burst_len);
        if (fifo_rd && load_last) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (m_valid && m_ready && m_last) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Control stage: state, per-burst word count and idle timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      issued     <= '0;
      burst_len  <= '0;
      idle_timer <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        burst_len <= len_nx;
        issued    <= '0;
      end else if (fifo_rd) begin
        issued <= issued_inc;
      end else if ((state == ST_DRAIN) && (state_nx == ST_IDLE)) begin
        issued <= '0;
      end
      // The timer only measures how long words have waited while no burst is open.
      if (state == ST_IDLE) begin
        if (start || (fifo_cntr == '0)) idle_timer <= '0;
        else if (idle_timer != TO)      idle_timer <= idle_timer + T_ONE;
      end
    end
  end

  fifo_burst_reader_stream_out_reg #(.DW(DW)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (fifo_rd),
    .load_data (fifo_dout),
    .load_last (load_last),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized and directed bench for fifo_burst_reader against a pop/accept counting model.
module tb_fifo_burst_reader;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int BL = 8;
  localparam int TO = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] fifo_dout;
  logic [AW:0]   fifo_cntr;
  logic          fifo_empty;
  logic          fifo_rd;
  logic          flush;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [AW:0]   burst_len;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  // environment FIFO contents and the model's own copy of written words
  logic [DW-1:0] fq[$];
  logic [DW-1:0] ref_q[$];
  bit            pop_now = 1'b0;

  // model: a burst is open (busy) from its decision until len beats are accepted
  bit            md_busy = 1'b0;
  int            md_len = 0, md_pop = 0, md_acc = 0, md_idle = 0;
  logic [DW-1:0] md_held = '0;
  int            lens[$];

  int            n_rd = 0, n_acc = 0, n_last = 0;
  logic [DW-1:0] last_data = '0;

  fifo_burst_reader #(.AW(AW), .DW(DW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_dout  (fifo_dout),
    .fifo_cntr  (fifo_cntr),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .flush      (flush),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .burst_len  (burst_len),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_cntr  = (AW+1)'(fq.size());
    fifo_empty = (fq.size() == 0);
    fifo_dout  = (fq.size() == 0) ? '0 : fq[0];
  endtask

  // one clock: FIFO pops on the DUT strobe, optional write, new stream/flush inputs
  task automatic cyc(input bit do_push, input logic [DW-1:0] w, input bit rdy, input bit fl);
    @(posedge clk);
    #1;
    if (pop_now && fq.size() > 0) void'(fq.pop_front());
    if (do_push && fq.size() < DEPTH) begin
      fq.push_back(w);
      ref_q.push_back(w);
    end
    m_ready = rdy;
    flush   = fl;
    drive_fifo();
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    int n;
    n = 0;
    do begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      n++;
    end while ((busy || fq.size() != 0) && n < maxc);
    chk(nm, (busy || fq.size() != 0), 0);
  endtask

  // compare process: check outputs against the model, then advance the model one edge
  always @(negedge clk) begin : cmp
    bit ev, er;
    if (!rst_n) begin
      ref_q.delete();
      md_busy = 1'b0;
      md_len  = 0;
      md_pop  = 0;
      md_acc  = 0;
      md_idle = 0;
      pop_now = 1'b0;
    end else begin
      ev = (md_pop > md_acc);
      er = md_busy && (md_pop < md_len) && !fifo_empty && (!ev || m_ready);
      chk("fifo_rd", fifo_rd, er);
      chk("m_valid", m_valid, ev);
      chk("busy", busy, md_busy);
      if (md_busy) chk("burst_len", burst_len, md_len);
      if (ev) begin
        chk("m_data", m_data, md_held);
        chk("m_last", m_last, (md_pop == md_len));
      end
      chk("rd_while_empty", fifo_rd && fifo_empty, 0);
      chk("rd_while_stalled", fifo_rd && m_valid && !m_ready, 0);
      if (fifo_rd) n_rd++;
      if (m_valid && m_ready) n_acc++;
      if (m_valid && m_ready && m_last) begin
        n_last++;
        last_data = m_data;
      end
      pop_now = fifo_rd;

      if (md_busy) begin
        if (ev && m_ready) md_acc++;
        if (er) begin
          if (ref_q.size() > 0) md_held = ref_q.pop_front();
          md_pop++;
        end
        if (md_acc == md_len) md_busy = 1'b0;
      end else if (int'(fifo_cntr) >= BL ||
                   (fifo_cntr != 0 && (flush || md_idle == TO))) begin
        md_busy = 1'b1;
        md_len  = (int'(fifo_cntr) >= BL) ? BL : int'(fifo_cntr);
        md_pop  = 0;
        md_acc  = 0;
        md_idle = 0;
        lens.push_back(md_len);
      end else if (fifo_cntr == 0) begin
        md_idle = 0;
      end else if (md_idle < TO) begin
        md_idle++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, acc0, rd0, last0;
    rst_n   = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    drive_fifo();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_burst_len", burst_len, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // full burst of 0x10..0x17
    rd0 = n_rd; last0 = n_last; base = lens.size();
    for (int i = 0; i < 8; i++) cyc(1'b1, 64'h10 + i, 1'b1, 1'b0);
    wait_idle("t1_done", 100);
    chk("t1_nbursts", lens.size() - base, 1);
    chk("t1_len", (lens.size() > base) ? lens[base] : -1, 8);
    chk("t1_rd_cycles", n_rd - rd0, 8);
    chk("t1_last_count", n_last - last0, 1);
    chk("t1_last_data", last_data, 64'h17);

    // three words released by the idle timeout
    base = lens.size();
    cyc(1'b1, 64'h20, 1'b1, 1'b0);
    n = 0;
    do begin
      n++;
      cyc(n <= 2, 64'h20 + n, 1'b1, 1'b0);
    end while (!fifo_rd && n < 100);
    chk("t2_timeout_delay", n, TO + 1);
    wait_idle("t2_done", 100);
    chk("t2_len", (lens.size() > base) ? lens[base] : -1, 3);
    chk("t2_last_data", last_data, 64'h22);

    // five words released by flush
    base = lens.size();
    for (int i = 0; i < 5; i++) cyc(1'b1, 64'h30 + i, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    n = 0;
    do begin
      n++;
      cyc(1'b0, '0, 1'b1, 1'b0);
    end while (!fifo_rd && n < 10);
    chk("t3_flush_delay", n, 1);
    wait_idle("t3_done", 100);
    chk("t3_len", (lens.size() > base) ? lens[base] : -1, 5);
    chk("t3_last_data", last_data, 64'h34);

    // stalled consumer, ready pattern 1,0,0,1
    base = lens.size(); acc0 = n_acc;
    for (int i = 0; i < 60; i++)
      cyc(i < 8, 64'(i), (i % 4 == 0) || (i % 4 == 3), 1'b0);
    wait_idle("t4_done", 100);
    chk("t4_len", (lens.size() > base) ? lens[base] : -1, 8);
    chk("t4_beats", n_acc - acc0, 8);
    chk("t4_last_data", last_data, 64'h7);

    // twenty back-to-back words: 8, 8, then 4 on timeout
    base = lens.size();
    for (int i = 0; i < 20; i++) cyc(1'b1, 64'h100 + i, 1'b1, 1'b0);
    wait_idle("t5_done", 200);
    chk("t5_nbursts", lens.size() - base, 3);
    if (lens.size() >= base + 3) begin
      chk("t5_len0", lens[base], 8);
      chk("t5_len1", lens[base+1], 8);
      chk("t5_len2", lens[base+2], 4);
    end
    chk("t5_last_data", last_data, 64'h113);

    // reset while beat 4 of a burst is on the stream
    acc0 = n_acc;
    for (int i = 0; i < 8; i++) cyc(1'b1, 64'h200 + i, 1'b1, 1'b0);
    n = 0;
    while (!(m_valid && (n_acc - acc0) == 3) && n < 50) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("t6_reached_beat4", m_valid && (n_acc - acc0) == 3, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_m_valid", m_valid, 0);
    chk("t6_async_fifo_rd", fifo_rd, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_burst_len", burst_len, 0);
    fq.delete();
    drive_fifo();
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("t6_post_busy", busy, 0);
    chk("t6_post_burst_len", burst_len, 0);
    chk("t6_post_m_valid", m_valid, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 9) < 4, {$urandom, $urandom},
          $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3);
    wait_idle("rand_done", 300);
    chk("rand_model_empty", ref_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
